ahb_to_wb_bridge: RTL and testbench
===================================

// Module: ahb_to_wb_bridge
// PURPOSE
//   AHB-Lite slave to Wishbone master bridge; drives the WBs_* bus of the FPGA IP aperture (register and reserved blocks).
//   Each AHB transfer becomes one Wishbone cycle; HREADYOUT is held low until WBs_ACK, then read data returns on HRDATA.
//   Rejects illegal size/alignment; optionally aborts on an unacknowledged Wishbone cycle.
// PARAMETERS
//   APERWIDTH           17            address width of the aperture (HADDR/WBs_ADR)
//   DATAWIDTH           32            data bus width (only 32 supported)
//   TIMEOUT_CYCLES      255           max STROBE cycles without WBs_ACK (AHB2WB_TIMEOUT_EN only)
//   TIMEOUT_CNTR_WIDTH  8             timeout counter width; must hold TIMEOUT_CYCLES
//   DEFAULT_READ_VALUE  32'hBAD_FAB_AC  HRDATA value on timeout
// PORTS
//   WB_CLK        in   1              single clock (AHB and Wishbone)
//   WB_RST        in   1              asynchronous active-high reset
//   HSEL          in   1              AHB slave select
//   HADDR         in   APERWIDTH      AHB byte address
//   HTRANS        in   2              AHB transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HWRITE        in   1              AHB write
//   HSIZE         in   3              AHB size (0=byte,1=half,2=word)
//   HWDATA        in   32             AHB write data (data phase)
//   HREADY        in   1              AHB bus ready (previous transfer done)
//   HREADYOUT     out  1              slave ready
//   HRESP         out  1              0=OKAY, 1=ERROR
//   HRDATA        out  32            read data, registered
//   WBs_ADR       out  APERWIDTH      Wishbone byte address
//   WBs_CYC       out  1              Wishbone cycle
//   WBs_STB       out  1              Wishbone strobe
//   WBs_WE        out  1              write enable
//   WBs_RD        out  1              read enable (= CYC & STB & ~WE)
//   WBs_BYTE_STB  out  4              byte enables
//   WBs_WR_DAT    out  32             write data
//   WBs_RD_DAT    in   32             read data from decode mux
//   WBs_ACK       in   1              Wishbone acknowledge
// BEHAVIOUR
//   Reset: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, WBs_CYC/STB/WE/RD=0, WBs_BYTE_STB=0, WBs_ADR=0, WBs_WR_DAT=0; timeout counter=0. Reset takes effect immediately in any state (drops CYC/STB mid-cycle).
//   Address phase is valid when HSEL & HREADY & HTRANS[1]. IDLE/BUSY, or HSEL=0: zero-wait OKAY, no Wishbone access.
//   IDLE: HREADYOUT=1, HRESP=0. Valid phase latches HADDR, HWRITE, HSIZE. Legal phase -> SETUP. Illegal -> ERR1: HSIZE>2, half with HADDR[0]=1, or word with HADDR[1:0]!=0.
//   SETUP (1 cycle): HREADYOUT=0. Register HWDATA into WBs_WR_DAT on writes. Byte strobes: byte 4'b0001<<HADDR[1:0]; half HADDR[1]?4'b1100:4'b0011; word 4'b1111. -> STROBE.
//   STROBE: WBs_CYC=WBs_STB=1, WE/RD from latched HWRITE, HREADYOUT=0. When WBs_ACK=1, drop CYC/STB next edge; reads capture WBs_RD_DAT into HRDATA; -> IDLE (HREADYOUT=1, OKAY).
//   Latency: ACK sampled in the n-th STROBE cycle gives a data phase of n+2 cycles (a registered slave with n=2 gives 4).
//   WBs_ACK outside STROBE is ignored. HRDATA holds its last value on writes and errors (except timeout).
//   ERR1: HREADYOUT=0, HRESP=1 -> ERR2: HREADYOUT=1, HRESP=1. ERR2 accepts a new valid address phase exactly as IDLE does.
//   Back-to-back: a valid address phase during the IDLE or ERR2 cycle that completes the previous transfer is accepted (pipelined).
// CONFIGURATION
//   AHB2WB_TIMEOUT_EN defined: counter runs in STROBE. After TIMEOUT_CYCLES cycles with no ACK: drop CYC/STB, HRDATA=DEFAULT_READ_VALUE, -> ERR1. An ACK in the final cycle wins.
//   Undefined: no counter; STROBE waits indefinitely for WBs_ACK.
// STRUCTURE
//   ahb2wb_pkg: HTRANS/HSIZE encodings, state enum {IDLE,SETUP,STROBE,ERR1,ERR2}, byte-strobe and alignment-check functions.
//   Sub-module wb_ack_timeout (load/count/expire, instantiated only under AHB2WB_TIMEOUT_EN).
// TESTING
//   Word write 0x00008=0xDEADBEEF, ACK 2nd STROBE cycle -> WBs_BYTE_STB=4'hF, WBs_WR_DAT=0xDEADBEEF, WBs_WE=1, HREADYOUT low 3 cycles, OKAY.
//   Byte read 0x00013, WBs_RD_DAT=0x11223344 -> WBs_BYTE_STB=4'b1000, WBs_RD=1, HRDATA=0x11223344 when HREADYOUT rises.
//   Half write 0x00001 / HSIZE=3 -> no WBs_CYC, HRESP=1 for 2 cycles, HREADYOUT 0 then 1.
//   Timeout (EN, TIMEOUT_CYCLES=4, ACK never) -> CYC drops after 4 STROBE cycles, HRDATA=0xBAD_FAB_AC, ERROR response; without EN, HREADYOUT stays 0.
//   WB_RST asserted mid-STROBE -> CYC/STB=0, HREADYOUT=1 without a clock edge; next transfer completes normally.

Source files
------------

// File: rtl/ahb2wb_pkg.sv
// Shared encodings, FSM state type and access-decode helpers for the AHB-Lite to Wishbone bridge.
package ahb2wb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_ERR1,
      S_ERR2
   } state_t;

   function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] addr_lo);
      case (size)
         HSIZE_BYTE: byte_strobe = 4'b0001 << addr_lo;
         HSIZE_HALF: byte_strobe = addr_lo[1] ? 4'b1100 : 4'b0011;
         default:    byte_strobe = 4'b1111;
      endcase
   endfunction

   // Sizes above a word and misaligned halves/words are answered with an AHB ERROR.
   function automatic logic access_legal(input logic [2:0] size, input logic [1:0] addr_lo);
      case (size)
         HSIZE_BYTE: access_legal = 1'b1;
         HSIZE_HALF: access_legal = ~addr_lo[0];
         HSIZE_WORD: access_legal = (addr_lo == 2'b00);
         default:    access_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ahb_to_wb_bridge_if.sv
// AHB-Lite slave side plus Wishbone master side of the bridge, bundled as one interface.
interface ahb_to_wb_bridge_if #(
   parameter int APERWIDTH = 17,
   parameter int DATAWIDTH = 32
);
   logic                   HSEL;
   logic [APERWIDTH-1:0]   HADDR;
   logic [1:0]             HTRANS;
   logic                   HWRITE;
   logic [2:0]             HSIZE;
   logic [DATAWIDTH-1:0]   HWDATA;
   logic                   HREADY;
   logic                   HREADYOUT;
   logic                   HRESP;
   logic [DATAWIDTH-1:0]   HRDATA;

   logic [APERWIDTH-1:0]   WBs_ADR;
   logic                   WBs_CYC;
   logic                   WBs_STB;
   logic                   WBs_WE;
   logic                   WBs_RD;
   logic [3:0]             WBs_BYTE_STB;
   logic [DATAWIDTH-1:0]   WBs_WR_DAT;
   logic [DATAWIDTH-1:0]   WBs_RD_DAT;
   logic                   WBs_ACK;

   // Bridge view: AHB slave, Wishbone master.
   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, WBs_RD_DAT, WBs_ACK,
      output HREADYOUT, HRESP, HRDATA,
             WBs_ADR, WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_BYTE_STB, WBs_WR_DAT
   );

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY, WBs_RD_DAT, WBs_ACK,
      input  HREADYOUT, HRESP, HRDATA,
             WBs_ADR, WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_BYTE_STB, WBs_WR_DAT
   );
endinterface

// File: rtl/ahb_to_wb_bridge_wb_ack_timeout.sv
// Counts STROBE cycles without acknowledge; o_expire flags the last allowed cycle.
module wb_ack_timeout #(
   parameter int CYCLES = 255,
   parameter int CNTR_W = 8
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_load,
   input  logic i_count,
   output logic o_expire
);

   localparam logic [CNTR_W-1:0] LAST = CNTR_W'(CYCLES - 1);

   logic [CNTR_W-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= '0;
      else if (i_count && (r_cnt != LAST))
         r_cnt <= r_cnt + CNTR_W'(1);
   end

   assign o_expire = i_count & (r_cnt == LAST);

endmodule

// File: rtl/ahb_to_wb_bridge.sv
// AHB-Lite slave to Wishbone master bridge, one Wishbone cycle per AHB transfer.
// Optional AHB2WB_TIMEOUT_EN aborts a Wishbone cycle that is never acknowledged.
module ahb_to_wb_bridge
   import ahb2wb_pkg::*;
#(
   parameter int          APERWIDTH          = 17,
   parameter int          DATAWIDTH          = 32,
   parameter int          TIMEOUT_CYCLES     = 255,
   parameter int          TIMEOUT_CNTR_WIDTH = 8,
   parameter logic [31:0] DEFAULT_READ_VALUE = 32'hBADFABAC
) (
   input  logic               WB_CLK,
   input  logic               WB_RST,
   ahb_to_wb_bridge_if.slave  bus
);

   if (DATAWIDTH != 32) begin : g_bad_width
      $error("ahb_to_wb_bridge supports DATAWIDTH = 32 only");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TIMEOUT_CNTR_WIDTH)) begin : g_bad_timeout
      $error("TIMEOUT_CNTR_WIDTH cannot hold TIMEOUT_CYCLES");
   end

   state_t                 r_state, w_next;
   logic                   r_write;
   logic [2:0]             r_size;
   logic [APERWIDTH-1:0]   r_adr;
   logic [3:0]             r_be;
   logic [DATAWIDTH-1:0]   r_wdat;
   logic [DATAWIDTH-1:0]   r_rdata;
   logic                   w_addr_valid;
   logic                   w_accept;
   logic                   w_legal;
   logic                   w_expire;

   assign w_addr_valid = bus.HSEL & bus.HREADY &
                         ((bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ));
   assign w_accept     = w_addr_valid & ((r_state == S_IDLE) || (r_state == S_ERR2));
   assign w_legal      = access_legal(bus.HSIZE, bus.HADDR[1:0]);

`ifdef AHB2WB_TIMEOUT_EN
   wb_ack_timeout #(
      .CYCLES (TIMEOUT_CYCLES),
      .CNTR_W (TIMEOUT_CNTR_WIDTH)
   ) u_timeout (
      .i_clk    (WB_CLK),
      .i_rst    (WB_RST),
      .i_load   (r_state == S_SETUP),
      .i_count  (r_state == S_STROBE),
      .o_expire (w_expire)
   );
`else
   assign w_expire = 1'b0;
`endif

   always_ff @(posedge WB_CLK or posedge WB_RST) begin
      if (WB_RST)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // ACK takes priority over expiry, so an acknowledge in the last allowed cycle still completes.
   always_comb begin
      w_next            = r_state;
      bus.HREADYOUT     = 1'b1;
      bus.HRESP         = 1'b0;
      bus.WBs_CYC       = 1'b0;
      bus.WBs_STB       = 1'b0;
      bus.WBs_WE        = 1'b0;
      bus.WBs_RD        = 1'b0;
      case (r_state)
         S_IDLE, S_ERR2: begin
            bus.HRESP = (r_state == S_ERR2);
            if (w_addr_valid)
               w_next = w_legal ? S_SETUP : S_ERR1;
            else
               w_next = S_IDLE;
         end
         S_SETUP: begin
            bus.HREADYOUT = 1'b0;
            w_next        = S_STROBE;
         end
         S_STROBE: begin
            bus.HREADYOUT = 1'b0;
            bus.WBs_CYC   = 1'b1;
            bus.WBs_STB   = 1'b1;
            bus.WBs_WE    = r_write;
            bus.WBs_RD    = ~r_write;
            if (bus.WBs_ACK)
               w_next = S_IDLE;
            else if (w_expire)
               w_next = S_ERR1;
         end
         S_ERR1: begin
            bus.HREADYOUT = 1'b0;
            bus.HRESP     = 1'b1;
            w_next        = S_ERR2;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge WB_CLK or posedge WB_RST) begin
      if (WB_RST) begin
         r_write <= 1'b0;
         r_size  <= 3'd0;
         r_adr   <= '0;
         r_be    <= 4'd0;
         r_wdat  <= '0;
         r_rdata <= '0;
      end else begin
         if (w_accept) begin
            r_adr   <= bus.HADDR;
            r_write <= bus.HWRITE;
            r_size  <= bus.HSIZE;
         end
         if (r_state == S_SETUP) begin
            r_be <= byte_strobe(r_size, r_adr[1:0]);
            if (r_write)
               r_wdat <= bus.HWDATA;
         end
         if (r_state == S_STROBE) begin
            if (bus.WBs_ACK) begin
               if (!r_write)
                  r_rdata <= bus.WBs_RD_DAT;
            end else if (w_expire) begin
               r_rdata <= DEFAULT_READ_VALUE;
            end
         end
      end
   end

   assign bus.HRDATA       = r_rdata;
   assign bus.WBs_ADR      = r_adr;
   assign bus.WBs_BYTE_STB = r_be;
   assign bus.WBs_WR_DAT   = r_wdat;

endmodule

// File: tb/tb_ahb_to_wb_bridge.sv
// Self-checking bench for ahb_to_wb_bridge; Wishbone cycles are recorded by a monitor and scored against a queue.
module tb_ahb_to_wb_bridge;
   import ahb2wb_pkg::*;

   localparam int AW = 17;

   typedef struct packed {
      logic          we;
      logic          rd;
      logic [AW-1:0] adr;
      logic [3:0]    be;
      logic [31:0]   dat;
   } wb_txn_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   wb_txn_t exp_q[$];
   wb_txn_t obs_q[$];

   ahb_to_wb_bridge_if #(.APERWIDTH(AW), .DATAWIDTH(32)) bus();

   ahb_to_wb_bridge #(
      .APERWIDTH          (AW),
      .DATAWIDTH          (32),
      .TIMEOUT_CYCLES     (4),
      .TIMEOUT_CNTR_WIDTH (8),
      .DEFAULT_READ_VALUE (32'hBADFABAC)
   ) dut (
      .WB_CLK (clk),
      .WB_RST (rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   assign bus.HREADY = bus.HREADYOUT;

   // Record every acknowledged Wishbone cycle as the bridge presents it.
   always @(negedge clk) begin
      if (bus.WBs_CYC && bus.WBs_STB && bus.WBs_ACK)
         obs_q.push_back('{we: bus.WBs_WE, rd: bus.WBs_RD, adr: bus.WBs_ADR, be: bus.WBs_BYTE_STB,
                           dat: bus.WBs_WE ? bus.WBs_WR_DAT : 32'h0});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one address phase now, then the data phase; ACK in the ack_n-th STROBE cycle (0 = never).
   task automatic run_xfer(input logic [AW-1:0] a, input logic w, input logic [2:0] sz,
                           input logic [31:0] wd, input logic [31:0] rd, input int ack_n,
                           input int budget, output int low, output int scyc,
                           output logic resp_end, output logic cyc_seen, output logic timed_out);
      bus.HSEL   = 1'b1;
      bus.HTRANS = HTRANS_NONSEQ;
      bus.HADDR  = a;
      bus.HWRITE = w;
      bus.HSIZE  = sz;
      tick();
      bus.HSEL   = 1'b0;
      bus.HTRANS = HTRANS_IDLE;
      bus.HWDATA = wd;
      bus.WBs_RD_DAT = rd;
      low = 0; scyc = 0; cyc_seen = 1'b0; timed_out = 1'b1; resp_end = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (bus.WBs_CYC) begin
            scyc++;
            cyc_seen = 1'b1;
         end
         bus.WBs_ACK = bus.WBs_CYC && (scyc == ack_n);
         if (bus.HREADYOUT) begin
            timed_out = 1'b0;
            resp_end  = bus.HRESP;
            break;
         end
         low++;
         tick();
      end
      bus.WBs_ACK = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0 || bus.HRDATA !== 32'h0) begin
         errors++;
         $display("FAIL reset_ahb: got rdy=%b resp=%b rdata=%h, required 1 0 00000000",
                  bus.HREADYOUT, bus.HRESP, bus.HRDATA);
      end
      checks++;
      if ({bus.WBs_CYC, bus.WBs_STB, bus.WBs_WE, bus.WBs_RD} !== 4'b0 || bus.WBs_BYTE_STB !== 4'h0 ||
          bus.WBs_ADR !== '0 || bus.WBs_WR_DAT !== 32'h0) begin
         errors++;
         $display("FAIL reset_wb: got ctl=%b be=%h adr=%h wdat=%h, required all zero",
                  {bus.WBs_CYC, bus.WBs_STB, bus.WBs_WE, bus.WBs_RD}, bus.WBs_BYTE_STB,
                  bus.WBs_ADR, bus.WBs_WR_DAT);
      end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_word_write();
      int low, scyc; logic resp, cyc, to;
      wb_txn_t got, exp;
      exp_q.push_back('{we: 1'b1, rd: 1'b0, adr: 17'h00008, be: 4'hF, dat: 32'hDEADBEEF});
      run_xfer(17'h00008, 1'b1, HSIZE_WORD, 32'hDEADBEEF, 32'h0, 2, 20, low, scyc, resp, cyc, to);
      checks++;
      if (low !== 3 || resp !== 1'b0 || to) begin
         errors++;
         $display("FAIL word_write_resp: got low=%0d resp=%b timeout=%b, required 3 0 0", low, resp, to);
      end
      checks++;
      if (obs_q.size() == 0) begin
         errors++;
         $display("FAIL word_write_txn: got no Wishbone cycle, required one");
      end else begin
         got = obs_q.pop_front();
         exp = exp_q.pop_front();
         if (got !== exp) begin
            errors++;
            $display("FAIL word_write_txn: got %h, required %h", got, exp);
         end
      end
   endtask

   task automatic test_byte_read();
      int low, scyc; logic resp, cyc, to;
      wb_txn_t got, exp;
      exp_q.push_back('{we: 1'b0, rd: 1'b1, adr: 17'h00013, be: 4'b1000, dat: 32'h0});
      run_xfer(17'h00013, 1'b0, HSIZE_BYTE, 32'h0, 32'h11223344, 1, 20, low, scyc, resp, cyc, to);
      checks++;
      if (bus.HRDATA !== 32'h11223344 || low !== 2 || resp !== 1'b0) begin
         errors++;
         $display("FAIL byte_read_data: got rdata=%h low=%0d resp=%b, required 11223344 2 0",
                  bus.HRDATA, low, resp);
      end
      checks++;
      if (obs_q.size() == 0) begin
         errors++;
         $display("FAIL byte_read_txn: got no Wishbone cycle, required one");
      end else begin
         got = obs_q.pop_front();
         exp = exp_q.pop_front();
         if (got !== exp) begin
            errors++;
            $display("FAIL byte_read_txn: got %h, required %h", got, exp);
         end
      end
   endtask

   // Illegal access, then a pipelined legal half read accepted in the ERR2 cycle.
   task automatic test_errors();
      int low, scyc; logic resp, cyc, to;
      wb_txn_t got, exp;
      run_xfer(17'h00001, 1'b1, HSIZE_HALF, 32'hCAFE0000, 32'h0, 1, 10, low, scyc, resp, cyc, to);
      checks++;
      if (low !== 1 || resp !== 1'b1 || cyc !== 1'b0) begin
         errors++;
         $display("FAIL misaligned_half: got low=%0d resp=%b cyc=%b, required 1 1 0", low, resp, cyc);
      end
      run_xfer(17'h00004, 1'b0, 3'd3, 32'h0, 32'h0, 1, 10, low, scyc, resp, cyc, to);
      checks++;
      if (low !== 1 || resp !== 1'b1 || cyc !== 1'b0) begin
         errors++;
         $display("FAIL size3: got low=%0d resp=%b cyc=%b, required 1 1 0", low, resp, cyc);
      end
      checks++;
      if (bus.HRDATA !== 32'h11223344) begin
         errors++;
         $display("FAIL err_hold_rdata: got %h, required 11223344", bus.HRDATA);
      end
      exp_q.push_back('{we: 1'b0, rd: 1'b1, adr: 17'h00002, be: 4'b1100, dat: 32'h0});
      run_xfer(17'h00002, 1'b0, HSIZE_HALF, 32'h0, 32'hA5A55A5A, 3, 20, low, scyc, resp, cyc, to);
      checks++;
      if (low !== 4 || resp !== 1'b0 || bus.HRDATA !== 32'hA5A55A5A) begin
         errors++;
         $display("FAIL after_err_read: got low=%0d resp=%b rdata=%h, required 4 0 a5a55a5a",
                  low, resp, bus.HRDATA);
      end
      checks++;
      if (obs_q.size() == 0) begin
         errors++;
         $display("FAIL after_err_txn: got no Wishbone cycle, required one");
      end else begin
         got = obs_q.pop_front();
         exp = exp_q.pop_front();
         if (got !== exp) begin
            errors++;
            $display("FAIL after_err_txn: got %h, required %h", got, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      int low, scyc; logic resp, cyc, to;
      wb_txn_t got, exp;
      exp_q.push_back('{we: 1'b1, rd: 1'b0, adr: 17'h1FFFC, be: 4'hF, dat: 32'h01234567});
      exp_q.push_back('{we: 1'b1, rd: 1'b0, adr: 17'h00006, be: 4'b1100, dat: 32'h89AB0000});
      run_xfer(17'h1FFFC, 1'b1, HSIZE_WORD, 32'h01234567, 32'h0, 1, 20, low, scyc, resp, cyc, to);
      run_xfer(17'h00006, 1'b1, HSIZE_HALF, 32'h89AB0000, 32'h0, 1, 20, low, scyc, resp, cyc, to);
      checks++;
      if (low !== 2 || resp !== 1'b0 || bus.HRDATA !== 32'hA5A55A5A) begin
         errors++;
         $display("FAIL b2b_second: got low=%0d resp=%b rdata=%h, required 2 0 a5a55a5a",
                  low, resp, bus.HRDATA);
      end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL b2b_txn%0d: got no Wishbone cycle, required one", i);
         end else begin
            got = obs_q.pop_front();
            exp = exp_q.pop_front();
            if (got !== exp) begin
               errors++;
               $display("FAIL b2b_txn%0d: got %h, required %h", i, got, exp);
            end
         end
      end
   endtask

   task automatic test_no_access();
      bus.HSEL   = 1'b1;
      bus.HTRANS = HTRANS_BUSY;
      bus.WBs_ACK = 1'b1;
      tick();
      bus.HTRANS = HTRANS_NONSEQ;
      bus.HSEL   = 1'b0;
      tick();
      checks++;
      if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0 || bus.WBs_CYC !== 1'b0 ||
          bus.HRDATA !== 32'hA5A55A5A) begin
         errors++;
         $display("FAIL no_access: got rdy=%b resp=%b cyc=%b rdata=%h, required 1 0 0 a5a55a5a",
                  bus.HREADYOUT, bus.HRESP, bus.WBs_CYC, bus.HRDATA);
      end
      bus.HTRANS  = HTRANS_IDLE;
      bus.WBs_ACK = 1'b0;
      tick();
   endtask

   task automatic test_timeout_and_reset();
      int low, scyc; logic resp, cyc, to;
      wb_txn_t got, exp;
`ifdef AHB2WB_TIMEOUT_EN
      run_xfer(17'h00010, 1'b0, HSIZE_WORD, 32'h0, 32'h0, 0, 20, low, scyc, resp, cyc, to);
      checks++;
      if (to || low !== 6 || scyc !== 4 || resp !== 1'b1 || bus.HRDATA !== 32'hBADFABAC) begin
         errors++;
         $display("FAIL timeout: got to=%b low=%0d strobes=%0d resp=%b rdata=%h, required 0 6 4 1 badfabac",
                  to, low, scyc, resp, bus.HRDATA);
      end
      run_xfer(17'h00010, 1'b0, HSIZE_WORD, 32'h0, 32'h5555AAAA, 4, 20, low, scyc, resp, cyc, to);
      checks++;
      if (to || low !== 5 || resp !== 1'b0 || bus.HRDATA !== 32'h5555AAAA) begin
         errors++;
         $display("FAIL ack_last_cycle: got to=%b low=%0d resp=%b rdata=%h, required 0 5 0 5555aaaa",
                  to, low, resp, bus.HRDATA);
      end
      void'(obs_q.pop_front());
      tick();
`endif
      run_xfer(17'h00020, 1'b1, HSIZE_WORD, 32'h0F0F0F0F, 32'h0, 0, 3, low, scyc, resp, cyc, to);
      checks++;
      if (!to || bus.WBs_CYC !== 1'b1 || bus.HREADYOUT !== 1'b0) begin
         errors++;
         $display("FAIL stall_strobe: got to=%b cyc=%b rdy=%b, required 1 1 0", to, bus.WBs_CYC, bus.HREADYOUT);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.WBs_CYC !== 1'b0 || bus.WBs_STB !== 1'b0 || bus.HREADYOUT !== 1'b1) begin
         errors++;
         $display("FAIL async_reset: got cyc=%b stb=%b rdy=%b, required 0 0 1",
                  bus.WBs_CYC, bus.WBs_STB, bus.HREADYOUT);
      end
      #1 rst = 1'b0;
      tick();
      exp_q.push_back('{we: 1'b0, rd: 1'b1, adr: 17'h00024, be: 4'hF, dat: 32'h0});
      run_xfer(17'h00024, 1'b0, HSIZE_WORD, 32'h0, 32'hFEEDC0DE, 2, 20, low, scyc, resp, cyc, to);
      checks++;
      if (to || low !== 3 || resp !== 1'b0 || bus.HRDATA !== 32'hFEEDC0DE) begin
         errors++;
         $display("FAIL post_reset_read: got to=%b low=%0d resp=%b rdata=%h, required 0 3 0 feedc0de",
                  to, low, resp, bus.HRDATA);
      end
      checks++;
      if (obs_q.size() != 1) begin
         errors++;
         $display("FAIL post_reset_txn: got %0d Wishbone cycles, required 1", obs_q.size());
      end else begin
         got = obs_q.pop_front();
         exp = exp_q.pop_front();
         if (got !== exp) begin
            errors++;
            $display("FAIL post_reset_txn: got %h, required %h", got, exp);
         end
      end
   endtask

   initial begin
      bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = HTRANS_IDLE; bus.HWRITE = 1'b0;
      bus.HSIZE = HSIZE_WORD; bus.HWDATA = 32'h0; bus.WBs_RD_DAT = 32'h0; bus.WBs_ACK = 1'b0;
      test_reset();
      test_word_write();
      test_byte_read();
      test_errors();
      tick();
      test_back_to_back();
      test_no_access();
      test_timeout_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
